// File: rtl/i2c_txn_fifo_if.sv
// Handshake bundle between the host/engine side and i2c_txn_fifo.
// With I2C_TXN_FIFO_ERR_EN defined it also carries err_clr/err_ovf/err_unf.
interface i2c_txn_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic              wr_rollback;
    logic              wr_full;
    logic              wr_afull;
    logic [ADDR_W:0]   wr_level;
    logic              rd_en;
    logic              rd_commit;
    logic              rd_rollback;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_empty;
    logic              rd_aempty;
    logic [ADDR_W:0]   rd_level;
`ifdef I2C_TXN_FIFO_ERR_EN
    logic              err_clr;
    logic              err_ovf;
    logic              err_unf;
`endif

    modport master (
`ifdef I2C_TXN_FIFO_ERR_EN
        output err_clr,
        input  err_ovf,
        input  err_unf,
`endif
        output wr_en,
        output wr_data,
        output wr_commit,
        output wr_rollback,
        input  wr_full,
        input  wr_afull,
        input  wr_level,
        output rd_en,
        output rd_commit,
        output rd_rollback,
        input  rd_data,
        input  rd_valid,
        input  rd_empty,
        input  rd_aempty,
        input  rd_level
    );

    modport slave (
`ifdef I2C_TXN_FIFO_ERR_EN
        input  err_clr,
        output err_ovf,
        output err_unf,
`endif
        input  wr_en,
        input  wr_data,
        input  wr_commit,
        input  wr_rollback,
        output wr_full,
        output wr_afull,
        output wr_level,
        input  rd_en,
        input  rd_commit,
        input  rd_rollback,
        output rd_data,
        output rd_valid,
        output rd_empty,
        output rd_aempty,
        output rd_level
    );
endinterface

// File: rtl/i2c_txn_fifo.sv
// Transactional FIFO with committed/speculative pointer pairs on both sides.
// Optional sticky overflow/underflow flags: define I2C_TXN_FIFO_ERR_EN.
module i2c_txn_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AFULL_TH  = 12,
    parameter int unsigned AEMPTY_TH = 2
) (
    input logic           clk,
    input logic           rstn,
    i2c_txn_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W:0] ptr_t;

    localparam ptr_t AFULL_LVL  = AFULL_TH[ADDR_W:0];
    localparam ptr_t AEMPTY_LVL = AEMPTY_TH[ADDR_W:0];
    localparam ptr_t DEPTH_LVL  = {1'b1, {ADDR_W{1'b0}}};

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t wr_cmt_q, wr_cmt_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t rd_cmt_q, rd_cmt_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic full;
    logic empty;
    logic wr_accept;
    logic rd_accept;
    ptr_t wr_level;
    ptr_t rd_level;

    // Writer is bounded by the read commit point so rewound reads stay intact;
    // the reader only sees data up to the write commit point.
    always_comb begin
        full     = (wr_ptr_q[ADDR_W] != rd_cmt_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_cmt_q[ADDR_W-1:0]);
        empty    = (rd_ptr_q == wr_cmt_q);
        wr_level = wr_ptr_q - rd_cmt_q;
        rd_level = wr_cmt_q - rd_ptr_q;
    end

    always_comb begin
        wr_accept = bus.wr_en && !full && !bus.wr_rollback;
        wr_ptr_d  = wr_ptr_q;
        wr_cmt_d  = wr_cmt_q;
        if (bus.wr_rollback) begin
            wr_ptr_d = wr_cmt_q;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (bus.wr_commit) begin
                wr_cmt_d = wr_ptr_d;
            end
        end
    end

    always_comb begin
        rd_accept  = bus.rd_en && !empty && !bus.rd_rollback;
        rd_ptr_d   = rd_ptr_q;
        rd_cmt_d   = rd_cmt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_accept;
        if (bus.rd_rollback) begin
            rd_ptr_d = rd_cmt_q;
        end else begin
            if (rd_accept) begin
                rd_ptr_d  = rd_ptr_q + ptr_t'(1);
                rd_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
            end
            if (bus.rd_commit) begin
                rd_cmt_d = rd_ptr_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            wr_cmt_q   <= '0;
            rd_ptr_q   <= '0;
            rd_cmt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_cmt_q   <= wr_cmt_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cmt_q   <= rd_cmt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    assign bus.wr_full   = full;
    assign bus.wr_afull  = (wr_level >= AFULL_LVL);
    assign bus.wr_level  = wr_level;
    assign bus.rd_empty  = empty;
    assign bus.rd_aempty = (rd_level <= AEMPTY_LVL);
    assign bus.rd_level  = rd_level;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;

`ifdef I2C_TXN_FIFO_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;

    // Set wins over clear so an error in the clearing cycle is not lost.
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        if (bus.err_clr) begin
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end
        if (bus.wr_en && full && !bus.wr_rollback) begin
            err_ovf_d = 1'b1;
        end
        if (bus.rd_en && empty && !bus.rd_rollback) begin
            err_unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign bus.err_ovf = err_ovf_q;
    assign bus.err_unf = err_unf_q;
`endif

`ifndef SYNTHESIS
    a_wr_level_bound : assert property (@(posedge clk) disable iff (!rstn)
        wr_level <= DEPTH_LVL);
    a_rd_level_bound : assert property (@(posedge clk) disable iff (!rstn)
        rd_level <= wr_level);
`endif

endmodule

// File: doc/i2c_txn_fifo.md
Name: i2c_txn_fifo

Overview:
Transactional FIFO for the I2C master datapath, successor to the single-snapshot I2C FIFO.
- Generalised data width and depth.
- Adds a committed/speculative pointer pair per side, so the reader sees only committed write data and the writer cannot overwrite unconfirmed read data.
- Adds level counts, almost-full/almost-empty flags and read-valid signalling.
- Sits between the host-side command/data path and the I2C bit engine. The engine rolls back on NACK or arbitration loss and commits on ACK.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 4, log2 of depth; depth = 2**ADDR_W (>=2)
AFULL_TH, 12, wr_afull asserted when wr_level >= AFULL_TH (1..2**ADDR_W)
AEMPTY_TH, 2, rd_aempty asserted when rd_level <= AEMPTY_TH (0..2**ADDR_W-1)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_data  in  DATA_W  write word
wr_commit  in  1  commit speculative writes (publish to reader)
wr_rollback  in  1  discard uncommitted writes
wr_full  out  1  no free slot for writer
wr_afull  out  1  almost full
wr_level  out  ADDR_W+1  slots used from writer view
rd_en  in  1  read request
rd_commit  in  1  commit reads (free slots to writer)
rd_rollback  in  1  rewind read pointer to last read commit
rd_data  out  DATA_W  read word, registered
rd_valid  out  1  rd_data updated this cycle
rd_empty  out  1  no committed word available
rd_aempty  out  1  almost empty
rd_level  out  ADDR_W+1  committed words unread

Behaviour:
- Pointers are ADDR_W+1 bits with a wrap bit: wr_ptr (speculative), wr_cmt, rd_ptr (speculative), rd_cmt. Reset: all 0, rd_data=0, rd_valid=0.
- rd_empty = (rd_ptr == wr_cmt).
- wr_full = (wr_ptr[ADDR_W] != rd_cmt[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_cmt[ADDR_W-1:0]).
- wr_level = wr_ptr - rd_cmt; rd_level = wr_cmt - rd_ptr. Both are modulo 2**(ADDR_W+1), range 0..depth.
- Flags, levels, full and empty are combinational from registered pointers.
- Write accepted iff wr_en && !wr_full && !wr_rollback. On acceptance: mem[wr_ptr[ADDR_W-1:0]] <= wr_data; wr_ptr += 1.
- wr_rollback: wr_ptr <= wr_cmt. A wr_en in the same cycle is discarded and memory is not written. wr_commit in the same cycle is ignored.
- wr_commit (without rollback): wr_cmt <= post-update wr_ptr, so a write accepted in the same cycle is included.
- Read accepted iff rd_en && !rd_empty && !rd_rollback. On acceptance: next cycle rd_data = mem[rd_ptr], rd_valid = 1, rd_ptr += 1. Latency is 1 clk.
- When no read is accepted: rd_valid = 0 and rd_data holds its value.
- rd_rollback: rd_ptr <= rd_cmt. rd_en is ignored that cycle; rd_commit that cycle is ignored.
- rd_commit (without rollback): rd_cmt <= post-update rd_ptr.
- A write and a read to the same address in the same cycle cannot occur, because a read requires committed data.
- Uncommitted written words are invisible to the reader. Uncommitted read words stay unavailable to the writer.
- Wrap-around: all pointer arithmetic is modulo 2**(ADDR_W+1). Full and empty stay correct across any number of wraps.
- Writing when full and reading when empty are ignored; no state changes.
- Reset mid-transaction: all pointers and snapshots are cleared immediately (async). Memory contents are don't-care and are not reset.

Optional Feature:
I2C_TXN_FIFO_ERR_EN
- Defined: adds input err_clr and sticky outputs err_ovf and err_unf, each reset 0.
  - err_ovf sets on wr_en && wr_full && !wr_rollback.
  - err_unf sets on rd_en && rd_empty && !rd_rollback.
  - Both clear on err_clr; set has priority over clear in the same cycle.
- Undefined: ports absent; illegal requests are silently ignored.

Test Plan:
1. Defaults. Write 0x11,0x22,0x33 without commit → rd_empty=1, rd_level=0, wr_level=3. Pulse wr_commit → rd_level=3. Read 3 → rd_data 0x11,0x22,0x33 each 1 clk after rd_en, with rd_valid pulses.
2. Write 0xA0,0xA1, commit. Write 0xB0,0xB1, then wr_rollback → wr_level=2. Next read sequence returns only 0xA0,0xA1, then rd_empty=1.
3. Commit 4 words 0x01..0x04. Read 2, rd_rollback → rd_level=4. Reread returns 0x01 again. Check wr_level stays 4 until rd_commit after 4 reads → wr_level=0.
4. Fill 16 words with commit → wr_full=1, wr_afull=1. Extra write 0xFF ignored (err_ovf=1 with macro). Read and commit all 16 → data intact, rd_empty=1. Repeat 3 times to cross pointer wrap → same results.
5. Same cycle wr_en(0x55)+wr_commit → 0x55 readable next cycle. Same cycle wr_en(0x66)+wr_rollback → 0x66 never readable, wr_level unchanged.
6. Assert rstn=0 mid-burst with 5 committed words → all levels 0, rd_empty=1, wr_full=0, rd_valid=0 asynchronously. Post-reset write/commit/read of 0x77 works.
